// File: rtl/gcd_pkg.sv
// rtl/gcd_pkg.sv - shared types and default sizes for the GCD arbiter
package gcd_pkg;
  typedef enum logic [1:0] {IDLE, CLEAR, RUN, RESP} state_t;

  localparam int DEF_NREQ  = 4;
  localparam int DEF_WIDTH = 8;
  localparam int IDX_W     = $clog2(DEF_NREQ);
endpackage

// File: rtl/gcd_arbiter_rr_pick.sv
// rtl/gcd_arbiter_rr_pick.sv - combinational round-robin selector
// Scans upward from i_ptr+1; the pointer's own slot has the lowest priority.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_grant,
  output logic [IW-1:0]   o_idx,
  output logic            o_valid
);
  int            w_cand;
  logic [IW-1:0] w_ci;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_cand  = 0;
    w_ci    = '0;
    // Walk from farthest to nearest so the nearest set bit is assigned last.
    for (int k = NREQ; k >= 1; k--) begin
      w_cand = (int'(i_ptr) + k) % NREQ;
      w_ci   = IW'(w_cand);
      if (i_req[w_ci]) begin
        o_grant       = '0;
        o_grant[w_ci] = 1'b1;
        o_idx         = w_ci;
        o_valid       = 1'b1;
      end
    end
  end
endmodule

// File: rtl/gcd_arbiter.sv
// rtl/gcd_arbiter.sv - round-robin sharing of one GCD engine between NREQ requesters
// Optional RUN timeout enabled by defining GCD_ARB_TIMEOUT_EN.
module gcd_arbiter
  import gcd_pkg::*;
#(
  parameter int NREQ    = DEF_NREQ,
  parameter int WIDTH   = DEF_WIDTH,
  parameter int TIMEOUT = 255
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic [NREQ-1:0]       i_req,
  input  logic [NREQ*WIDTH-1:0] i_num0,
  input  logic [NREQ*WIDTH-1:0] i_num1,
  output logic [NREQ-1:0]       o_ack,
  output logic [NREQ-1:0]       o_done,
  output logic [WIDTH-1:0]      o_result,
  output logic                  o_err,
  output logic                  o_busy,
  output logic                  o_eng_clear,
  output logic                  o_eng_start,
  output logic [WIDTH-1:0]      o_eng_num0,
  output logic [WIDTH-1:0]      o_eng_num1,
  input  logic [WIDTH-1:0]      i_eng_greatest,
  input  logic                  i_eng_success
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [NREQ-1:0] ONE = NREQ'(1);

  state_t            r_state;
  logic [IW-1:0]     r_ptr, r_idx;
  logic [WIDTH-1:0]  r_num0, r_num1, r_result;
  logic [NREQ-1:0]   r_ack, r_done;
  logic              r_err, r_busy, r_eng_clear, r_eng_start;

  logic [NREQ-1:0]   w_grant;
  logic [IW-1:0]     w_idx;
  logic              w_valid;
  logic [WIDTH-1:0]  w_sel0, w_sel1;

`ifdef GCD_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0]     r_cnt;
`else
  logic              w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT != 0);
`endif

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .i_req   (i_req),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_valid (w_valid)
  );

  assign w_sel0 = i_num0[w_idx*WIDTH +: WIDTH];
  assign w_sel1 = i_num1[w_idx*WIDTH +: WIDTH];

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= IDLE;
      r_ptr       <= IW'(NREQ - 1);
      r_idx       <= '0;
      r_num0      <= '0;
      r_num1      <= '0;
      r_result    <= '0;
      r_ack       <= '0;
      r_done      <= '0;
      r_err       <= 1'b0;
      r_busy      <= 1'b0;
      r_eng_clear <= 1'b1;
      r_eng_start <= 1'b0;
`ifdef GCD_ARB_TIMEOUT_EN
      r_cnt       <= '0;
`endif
    end else begin
      r_ack       <= '0;
      r_eng_clear <= 1'b0;
      case (r_state)
        IDLE: begin
          r_done   <= '0;
          r_err    <= 1'b0;
          r_result <= '0;
          if (w_valid) begin
            r_idx  <= w_idx;
            r_ptr  <= w_idx;
            r_num0 <= w_sel0;
            r_num1 <= w_sel1;
            r_ack  <= w_grant;
            r_busy <= 1'b1;
            // gcd(0,x) = x: answer directly and leave the engine idle
            if (w_sel0 == '0 || w_sel1 == '0) begin
              r_result <= w_sel0 | w_sel1;
              r_state  <= RESP;
            end else begin
              r_eng_clear <= 1'b1;
              r_state     <= CLEAR;
            end
          end
        end
        CLEAR: begin
          r_eng_start <= 1'b1;
          r_state     <= RUN;
`ifdef GCD_ARB_TIMEOUT_EN
          r_cnt       <= '0;
`endif
        end
        RUN: begin
          if (i_eng_success) begin
            r_result    <= i_eng_greatest;
            r_done      <= ONE << r_idx;
            r_eng_start <= 1'b0;
            r_state     <= RESP;
          end
`ifdef GCD_ARB_TIMEOUT_EN
          else if (r_cnt == CW'(TIMEOUT - 1)) begin
            r_result    <= '0;
            r_err       <= 1'b1;
            r_done      <= ONE << r_idx;
            r_eng_start <= 1'b0;
            r_state     <= RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
`endif
        end
        RESP: begin
          // Zero-operand jobs arrive here with done still clear and spend one extra cycle.
          if (r_done == '0) begin
            r_done <= ONE << r_idx;
          end else begin
            r_done   <= '0;
            r_err    <= 1'b0;
            r_result <= '0;
            r_busy   <= 1'b0;
            r_state  <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_ack       = r_ack;
  assign o_done      = r_done;
  assign o_result    = r_result;
`ifdef GCD_ARB_TIMEOUT_EN
  assign o_err       = r_err;
`else
  assign o_err       = 1'b0;
`endif
  assign o_busy      = r_busy;
  assign o_eng_clear = r_eng_clear;
  assign o_eng_start = r_eng_start;
  assign o_eng_num0  = r_num0;
  assign o_eng_num1  = r_num1;
endmodule

// File: tb/tb_gcd_arbiter.sv
// tb/tb_gcd_arbiter.sv - directed self-checking bench for gcd_arbiter
module tb_gcd_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [31:0] num0 = '0, num1 = '0;
  logic [3:0]  o_ack, o_done;
  logic [7:0]  o_result, o_eng_num0, o_eng_num1;
  logic        o_err, o_busy, o_eng_clear, o_eng_start;
  logic [7:0]  eng_greatest = '0;
  logic        eng_success = 1'b0;

  int total = 0;
  int bad   = 0;
  int eng_lat = 3;
  int eng_cnt = 0;
  int ack3_cnt = 0;

  int ack_c, nack, done_c, starts, clears, a3;
  logic [3:0] ack_v, done_v;
  logic [7:0] res;
  logic       err_v;
  int exp_tab[4] = '{9, 3, 3, 9};

  gcd_arbiter #(.NREQ(4), .WIDTH(8), .TIMEOUT(10)) dut (
    .i_clock        (clk),
    .i_reset        (rst),
    .i_req          (req),
    .i_num0         (num0),
    .i_num1         (num1),
    .o_ack          (o_ack),
    .o_done         (o_done),
    .o_result       (o_result),
    .o_err          (o_err),
    .o_busy         (o_busy),
    .o_eng_clear    (o_eng_clear),
    .o_eng_start    (o_eng_start),
    .o_eng_num0     (o_eng_num0),
    .o_eng_num1     (o_eng_num1),
    .i_eng_greatest (eng_greatest),
    .i_eng_success  (eng_success)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gcd(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] x, y, t;
    x = a; y = b;
    while (y != 0) begin
      t = x % y; x = y; y = t;
    end
    return x;
  endfunction

  // Engine model: raises success eng_lat cycles after start goes high; eng_lat=0 never finishes
  always @(negedge clk) begin
    if (rst || o_eng_clear || !o_eng_start) begin
      eng_cnt = 0;
      eng_success = 1'b0;
      eng_greatest = '0;
    end else begin
      eng_cnt = eng_cnt + 1;
      if (eng_lat > 0 && eng_cnt >= eng_lat) begin
        eng_success = 1'b1;
        eng_greatest = gcd(o_eng_num0, o_eng_num1);
      end
    end
  end

  always @(negedge clk) if (o_ack[3]) ack3_cnt = ack3_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
    num0[i*8 +: 8] = a;
    num1[i*8 +: 8] = b;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_job(input int max_c);
    ack_c = -1; nack = 0; done_c = -1; starts = 0; clears = 0;
    ack_v = '0; done_v = '0; res = '0; err_v = 1'b0;
    for (int c = 1; c <= max_c; c++) begin
      @(negedge clk);
      if (|o_ack) begin
        nack += $countones(o_ack);
        if (ack_c < 0) begin
          ack_c = c;
          ack_v = o_ack;
        end
      end
      starts += int'(o_eng_start);
      clears += int'(o_eng_clear);
      if (|o_done) begin
        done_c = c;
        done_v = o_done;
        res    = o_result;
        err_v  = o_err;
        break;
      end
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_eng_clear", o_eng_clear, 1);
    check("rst_busy", o_busy, 0);
    check("rst_ack", o_ack, 0);
    check("rst_done", o_done, 0);
    check("rst_start", o_eng_start, 0);
    check("rst_err", o_err, 0);
    check("rst_result", o_result, 0);
    rst = 1'b0;
    @(negedge clk);
    check("clear_falls", o_eng_clear, 0);

    eng_lat = 6;
    set_op(0, 36, 24);
    req = 4'b0001;
    run_job(50);
    req = '0;
    check("t1_ack_cyc", ack_c, 1);
    check("t1_ack_vec", ack_v, 4'b0001);
    check("t1_nack", nack, 1);
    check("t1_clears", clears, 1);
    check("t1_starts", starts, 6);
    check("t1_done_cyc", done_c, 8);
    check("t1_done_vec", done_v, 4'b0001);
    check("t1_result", res, 12);
    check("t1_err", err_v, 0);
    @(negedge clk);
    check("t1_idle_busy", o_busy, 0);

    do_reset();
    eng_lat = 3;
    for (int i = 0; i < 4; i++) set_op(i, 8'(i * 6), 9);
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      run_job(40);
      check("rr_ack_vec", ack_v, 4'b0001 << (k % 4));
      check("rr_nack", nack, 1);
      check("rr_done_vec", done_v, 4'b0001 << (k % 4));
      check("rr_result", res, exp_tab[k % 4]);
    end
    req = '0;
    @(negedge clk);
    check("rr_idle_busy", o_busy, 0);

    do_reset();
    set_op(2, 0, 45);
    req = 4'b0100;
    run_job(10);
    check("z_ack_cyc", ack_c, 1);
    check("z_done_cyc", done_c, 2);
    check("z_done_vec", done_v, 4'b0100);
    check("z_result", res, 45);
    check("z_starts", starts, 0);
    check("z_clears", clears, 0);
    set_op(2, 0, 0);
    run_job(10);
    req = '0;
    check("zz_done_cyc", done_c, 3);
    check("zz_result", res, 0);
    check("zz_starts", starts, 0);

    do_reset();
    eng_lat = 0;
    set_op(1, 10, 4);
    req = 4'b0010;
    repeat (4) @(negedge clk);
    check("mr_running", o_eng_start, 1);
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    check("mr_clear", o_eng_clear, 1);
    check("mr_busy", o_busy, 0);
    check("mr_done", o_done, 0);
    @(negedge clk);
    rst = 1'b0;
    eng_lat = 3;
    set_op(0, 8, 12);
    set_op(3, 5, 5);
    req = 4'b1001;
    run_job(20);
    req = '0;
    check("mr_ack_vec", ack_v, 4'b0001);
    check("mr_done_vec", done_v, 4'b0001);
    check("mr_result", res, 4);

    do_reset();
    eng_lat = 5;
    a3 = ack3_cnt;
    set_op(1, 20, 15);
    req = 4'b0010;
    @(negedge clk);
    check("ld_ack1", o_ack, 4'b0010);
    @(negedge clk);
    req = 4'b1000;
    repeat (2) @(negedge clk);
    req = '0;
    run_job(30);
    check("ld_done_vec", done_v, 4'b0010);
    check("ld_result", res, 5);
    repeat (4) @(negedge clk);
    check("ld_no_ack3", ack3_cnt, a3);

    do_reset();
    eng_lat = 0;
    set_op(0, 7, 5);
    req = 4'b0001;
`ifdef GCD_ARB_TIMEOUT_EN
    run_job(100);
    req = '0;
    check("to_done_cyc", done_c, 12);
    check("to_done_vec", done_v, 4'b0001);
    check("to_err", err_v, 1);
    check("to_result", res, 0);
    check("to_starts", starts, 10);
`else
    run_job(1000);
    req = '0;
    check("nt_done_cyc", done_c, -1);
    check("nt_busy", o_busy, 1);
    check("nt_starts", starts, 999);
`endif
    do_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/gcd_arbiter.md
Name: gcd_arbiter

Overview:
- Shares one GCD engine (clear/start/num0/num1 in, greatest/success out) between NREQ requesters.
- Grants requesters round-robin and latches the winner's operands.
- Sequences the engine through clear → start → wait-for-success, then returns the result to the winner with a one-cycle done pulse.
- Sits between the client blocks and the single GCD instance.

Parameters:
NREQ, 4, number of requesters (2..8)
WIDTH, 8, operand/result width
TIMEOUT, 255, max RUN cycles before abort (used only with the optional feature)

Ports:
_clock  in  1  system clock, rising edge
_reset  in  1  asynchronous, active-high reset
_req  in  NREQ  per-requester request level
_num0  in  NREQ*WIDTH  packed operand A, requester i at [i*WIDTH +: WIDTH]
_num1  in  NREQ*WIDTH  packed operand B, same packing
_ack  out  NREQ  one-hot, one-cycle pulse: operands captured
_done  out  NREQ  one-hot, one-cycle pulse: _result valid for that requester
_result  out  WIDTH  GCD result, valid only while a _done bit is high
_err  out  1  high together with _done when the job timed out
_busy  out  1  high in every state except IDLE
_eng_clear  out  1  engine reset/zero
_eng_start  out  1  engine start, held for the whole RUN state
_eng_num0  out  WIDTH  latched operand A
_eng_num1  out  WIDTH  latched operand B
_eng_greatest  in  WIDTH  engine result
_eng_success  in  1  engine finished

Behaviour:
- One clock, _clock. _reset is asynchronous and active-high.
- Reset values:
  - state = IDLE; round-robin pointer = NREQ-1, so requester 0 wins first.
  - _eng_clear = 1; every other output = 0.
  - _eng_clear falls at the first clock edge after reset release.
- All outputs are registered.
- States: IDLE, CLEAR, RUN, RESP.
- IDLE:
  - If any _req bit is set, the winner is the first set bit scanning upward (modulo NREQ) from pointer+1.
  - On that edge: latch the winner's operands and index, set pointer = winner, pulse _ack[winner] next cycle.
  - If either latched operand is 0: result = the other operand (0 if both are 0), go straight to RESP without touching the engine.
  - Otherwise go to CLEAR.
- CLEAR: _eng_clear = 1 and _eng_start = 0 for exactly one cycle, then RUN.
- RUN:
  - _eng_start = 1; _eng_num0/_eng_num1 hold the latched operands.
  - On the first cycle _eng_success is sampled high: latch _eng_greatest, go to RESP.
- RESP:
  - _done[winner] = 1 and _result valid for exactly one cycle, then IDLE.
  - _eng_start drops on entry to RESP.
- Handshake rules:
  - A requester holds _req and stable operands until it sees _ack.
  - After _ack, _req is don't-care until _done.
  - _req still high in the cycle after _done counts as a new request.
- Latency, request sampled at edge 0:
  - _ack high in cycle 1.
  - Engine path: CLEAR in cycle 1, RUN from cycle 2; _done high in the cycle after success is sampled.
  - Zero-operand path: _done high in cycle 2.
- Back-to-back: the earliest new grant is at the edge that leaves RESP; IDLE lasts at least one cycle.
- Simultaneous requests: exactly one _ack bit per grant. Losers stay pending and are never dropped.
- A _req that drops before being granted is ignored.
- _eng_success outside RUN is ignored.
- Reset asserted mid-job: the job is aborted silently; no _done is issued and the pointer resets.

Optional Feature:
GCD_ARB_TIMEOUT_EN
- Defined:
  - A $clog2(TIMEOUT+1)-bit counter clears on entering RUN and increments each RUN cycle.
  - If the counter reaches TIMEOUT with no success: go to RESP with _result = 0 and _err = 1.
  - Success and timeout in the same cycle: success wins.
- Undefined: RUN waits indefinitely, _err is tied to 0, and TIMEOUT is unused.

Decomposition:
- Package gcd_pkg:
  - state enum (IDLE, CLEAR, RUN, RESP);
  - default WIDTH and NREQ constants;
  - index width localparam $clog2(NREQ).
- One natural sub-module, rr_pick: combinational round-robin selector.
  - Inputs: req vector, pointer.
  - Outputs: one-hot grant, index, any-valid.

Test Plan:
- Single request: requester 0, num0 = 36, num1 = 24; engine returns 12 after 6 RUN cycles → _ack[0] in cycle 1, one CLEAR cycle, _done[0] with _result = 12 and _err = 0; _busy low afterwards.
- Contention: _req = 4'b1111 held from reset, operands i*6 and 9 → grant order 0, 1, 2, 3, 0; exactly one _ack per grant; each _done matches its own operands.
- Zero operand: requester 2, num0 = 0, num1 = 45 → _result = 45, _done[2] in cycle 2, _eng_start never high. Both operands 0 → _result = 0.
- Reset mid-RUN: requester 1 granted, _reset pulsed for 2 cycles during RUN → no _done; _eng_clear = 1 during reset; next request from requester 3 while requester 0 is also requesting → requester 0 wins.
- Timeout (feature defined, TIMEOUT = 10): engine never asserts success → _done with _err = 1 and _result = 0 exactly 10 RUN cycles after entry. With the feature undefined, the arbiter is still busy after 1000 cycles.
- Late drop: requester 3 raises then drops _req while requester 1 holds the grant → no _ack[3] is ever issued.
